// File: rtl/iir_stage_scheduler.sv
// Time-multiplexed cascade of first-order low-pass IIR stages sharing one update datapath.
// One stage is updated per cycle. Per-stage state lives in a register bank.
module iir_stage_scheduler #(
   parameter int unsigned N_STAGES = 5,
   parameter int unsigned K_SHIFT  = 4,
   parameter int unsigned DATA_W   = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [15:0]              settle_samples,
   input  logic                     data_valid,
   input  logic signed [DATA_W-1:0] data,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] data_out,
   output logic                     data_out_valid,
   output logic                     ready,
   output logic                     fifo_lleno
);

   localparam int unsigned IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

   typedef enum logic [0:0] {StIdle, StRun} state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [IDX_W-1:0]         r_idx;
   logic signed [DATA_W-1:0] r_y [N_STAGES];
   logic signed [DATA_W-1:0] r_u;
   logic signed [DATA_W-1:0] r_dout;
   logic [15:0]              r_count;
   logic                     r_dov;
   logic                     r_ready;
   logic                     r_lleno;

   logic                     w_accept;
   logic                     w_step;
   logic                     w_overrun;
   logic                     w_last;
   logic signed [DATA_W-1:0] w_y_cur;
   logic signed [DATA_W-1:0] w_y_new;
   logic signed [DATA_W:0]   w_diff;
   logic signed [DATA_W:0]   w_shift;

   // Shared datapath: difference one bit wider, floor via arithmetic shift, then truncate.
   assign w_y_cur = r_y[r_idx];
   assign w_diff  = {r_u[DATA_W-1], r_u} - {w_y_cur[DATA_W-1], w_y_cur};
   assign w_shift = w_diff >>> K_SHIFT;
   assign w_y_new = w_y_cur + w_shift[DATA_W-1:0];
   assign w_last  = (r_idx == LAST_IDX);

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_overrun   = 1'b0;
      case (r_state)
         StIdle: begin
            if (enable && data_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = StRun;
            end
         end
         StRun: begin
            if (enable) begin
               w_step    = 1'b1;
               w_overrun = data_valid;
               if (w_last) begin
                  w_state_nxt = StIdle;
               end
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < int'(N_STAGES); i++) begin
            r_y[i] <= '0;
         end
         r_idx   <= '0;
         r_u     <= '0;
         r_dout  <= '0;
         r_dov   <= 1'b0;
         r_count <= '0;
         r_ready <= 1'b0;
         r_lleno <= 1'b0;
      end else begin
         r_dov <= w_step && w_last;
         if (w_accept) begin
            r_u   <= data;
            r_idx <= '0;
         end
         // r_u doubles as the inter-stage carry: next stage consumes the value just written.
         if (w_step) begin
            r_y[r_idx] <= w_y_new;
            r_u        <= w_y_new;
            r_idx      <= w_last ? '0 : r_idx + 1'b1;
         end
         if (w_step && w_last) begin
            r_dout <= w_y_new;
            if (r_count != 16'hFFFF) begin
               r_count <= r_count + 16'd1;
            end
         end
         if (w_overrun) begin
            r_lleno <= 1'b1;
         end
         if (r_count >= settle_samples) begin
            r_ready <= 1'b1;
         end
      end
   end

   assign in_ready       = (r_state == StIdle) && enable && reset;
   assign data_out       = r_dout;
   assign data_out_valid = r_dov;
   assign ready          = r_ready;
   assign fifo_lleno     = r_lleno;

endmodule

// File: tb/tb_iir_stage_scheduler.sv
// Directed bench for iir_stage_scheduler: step, floor rounding, overrun, mid-run reset,
// freeze and settle/ready behaviour with default parameters.
module tb_iir_stage_scheduler;

   logic               clock = 1'b0;
   logic               reset;
   logic               enable;
   logic [15:0]        settle_samples;
   logic               data_valid;
   logic signed [63:0] data;
   logic               in_ready;
   logic signed [63:0] data_out;
   logic               data_out_valid;
   logic               ready;
   logic               fifo_lleno;

   int checks   = 0;
   int failures = 0;
   int lat;
   int n;

   always #5 clock = ~clock;

   iir_stage_scheduler #(
      .N_STAGES (5),
      .K_SHIFT  (4),
      .DATA_W   (64)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .settle_samples (settle_samples),
      .data_valid     (data_valid),
      .data           (data),
      .in_ready       (in_ready),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .ready          (ready),
      .fifo_lleno     (fifo_lleno)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Enter the next cycle just after its rising edge; inputs are driven here.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic smp();
      @(negedge clock);
   endtask

   task automatic do_reset();
      cyc();
      reset      = 1'b0;
      data_valid = 1'b0;
      enable     = 1'b1;
      smp();
      chk("rst_in_ready_low", in_ready, 64'd0);
      cyc();
      cyc();
      reset = 1'b1;
      smp();
   endtask

   // Accept a sample in cycle t; returns positioned in cycle t+1 with data_valid low.
   task automatic accept(input logic signed [63:0] d);
      cyc();
      data       = d;
      data_valid = 1'b1;
      smp();
      chk("accept_in_ready", in_ready, 64'd1);
      cyc();
      data_valid = 1'b0;
   endtask

   // Bounded wait for the output strobe; lat is cycles after acceptance, -1 on timeout.
   task automatic wait_out(input int start, output int l);
      l = -1;
      for (int i = start; i < start + 20; i++) begin
         smp();
         if (data_out_valid === 1'b1) begin
            l = i;
            break;
         end
         cyc();
      end
   endtask

   task automatic count_strobes(input int cycles, output int c);
      c = 0;
      for (int i = 0; i < cycles; i++) begin
         cyc();
         smp();
         if (data_out_valid === 1'b1) c++;
      end
   endtask

   initial begin
      reset          = 1'b0;
      enable         = 1'b1;
      data_valid     = 1'b0;
      data           = '0;
      settle_samples = 16'd100;

      // Reset state
      do_reset();
      chk("rst_data_out", data_out, 64'd0);
      chk("rst_dov", data_out_valid, 64'd0);
      chk("rst_ready", ready, 64'd0);
      chk("rst_fifo", fifo_lleno, 64'd0);
      chk("rst_in_ready_high", in_ready, 64'd1);

      // Step of 1600: y0=100, y1=6, rest 0
      accept(64'sd1600);
      wait_out(1, lat);
      chk("step_latency", 64'(lat), 64'd6);
      chk("step_data_out", data_out, 64'd0);
      chk("step_in_ready", in_ready, 64'd1);
      chk("step_y0", dut.r_y[0], 64'd100);
      chk("step_y1", dut.r_y[1], 64'd6);
      chk("step_y2", dut.r_y[2], 64'd0);
      chk("step_y4", dut.r_y[4], 64'd0);
      cyc();
      smp();
      chk("step_dov_one_cycle", data_out_valid, 64'd0);

      // Negative input: floor rounding drives every stage to -1
      do_reset();
      accept(-64'sd16);
      wait_out(1, lat);
      chk("neg_latency", 64'(lat), 64'd6);
      chk("neg_data_out", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("neg_y0", dut.r_y[0], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("neg_y2", dut.r_y[2], 64'hFFFF_FFFF_FFFF_FFFF);
      cyc();
      smp();
      chk("neg_dov_low", data_out_valid, 64'd0);
      chk("neg_data_out_hold", data_out, 64'hFFFF_FFFF_FFFF_FFFF);

      // Overrun: second data_valid at t+2 is dropped
      do_reset();
      accept(64'sd1600);
      smp();
      chk("ovr_fifo_before", fifo_lleno, 64'd0);
      cyc();
      data       = 64'sd5000;
      data_valid = 1'b1;
      smp();
      chk("ovr_in_ready_busy", in_ready, 64'd0);
      cyc();
      data_valid = 1'b0;
      smp();
      chk("ovr_fifo_t3", fifo_lleno, 64'd1);
      cyc();
      wait_out(4, lat);
      chk("ovr_latency", 64'(lat), 64'd6);
      chk("ovr_data_out", data_out, 64'd0);
      count_strobes(10, n);
      chk("ovr_no_second_strobe", 64'(n), 64'd0);
      for (int k = 0; k < 20; k++) begin
         accept(64'sd32);
         wait_out(1, lat);
      end
      chk("ovr_last_latency", 64'(lat), 64'd6);
      chk("ovr_fifo_sticky", fifo_lleno, 64'd1);

      // Reset in the middle of a run discards the sample
      do_reset();
      accept(64'sd1600);
      cyc();
      cyc();
      reset = 1'b0;
      smp();
      chk("mid_y0_before_rst", dut.r_y[0], 64'd100);
      cyc();
      reset = 1'b1;
      smp();
      chk("mid_y0_cleared", dut.r_y[0], 64'd0);
      chk("mid_y1_cleared", dut.r_y[1], 64'd0);
      chk("mid_data_out", data_out, 64'd0);
      chk("mid_dov", data_out_valid, 64'd0);
      chk("mid_fifo", fifo_lleno, 64'd0);
      count_strobes(10, n);
      chk("mid_no_strobe", 64'(n), 64'd0);
      accept(64'sd1600);
      wait_out(1, lat);
      chk("mid_resend_latency", 64'(lat), 64'd6);
      chk("mid_resend_y0", dut.r_y[0], 64'd100);
      chk("mid_resend_y1", dut.r_y[1], 64'd6);

      // Freeze for cycles t+2..t+4 delays the strobe to t+9
      do_reset();
      accept(64'sd1600);
      cyc();
      enable = 1'b0;
      cyc();
      data       = 64'sd777;
      data_valid = 1'b1;
      smp();
      chk("frz_in_ready_low", in_ready, 64'd0);
      cyc();
      data_valid = 1'b0;
      cyc();
      enable = 1'b1;
      wait_out(5, lat);
      chk("frz_latency", 64'(lat), 64'd9);
      chk("frz_data_out", data_out, 64'd0);
      chk("frz_y0", dut.r_y[0], 64'd100);
      chk("frz_y1", dut.r_y[1], 64'd6);
      chk("frz_fifo", fifo_lleno, 64'd0);

      // Ready after 3 back-to-back outputs
      settle_samples = 16'd3;
      do_reset();
      chk("rdy_after_reset", ready, 64'd0);
      accept(64'sd500);
      for (int k = 1; k <= 3; k++) begin
         wait_out(1, lat);
         chk("rdy_latency", 64'(lat), 64'd6);
         chk("rdy_low_at_strobe", ready, 64'd0);
         if (k < 3) begin
            chk("rdy_b2b_in_ready", in_ready, 64'd1);
            data       = 64'sd500;
            data_valid = 1'b1;
            cyc();
            data_valid = 1'b0;
         end
      end
      cyc();
      smp();
      chk("rdy_high_after_third", ready, 64'd1);
      do_reset();
      chk("rdy_cleared_by_reset", ready, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
